// File: rtl/message_comm_tx.sv
// Serial message transmitter: 16-bit length header, N payload bytes and an XOR
// checksum, shifted out MSB first on MSG_TX with MSG_TX_FSX framing each message.
module message_comm_tx #(
    parameter int GAP_CYCLES = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             msg_tx_len_en_i,
    input  logic [LEN_W-1:0] msg_tx_len_i,
    input  logic             msg_tx_data_vld_i,
    input  logic [7:0]       msg_tx_data_i,
    output logic             msg_tx_data_rdy_o,
    output logic             msg_tx_busy_o,
    output logic             msg_tx_done_o,
    output logic             msg_tx_err_o,
    output logic             MSG_TX_FSX,
    output logic             MSG_TX
);

    localparam int BIT_W = $clog2(LEN_W);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, GAP} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, load_cnt_q, slot_cnt_q, shift_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [7:0]       hold_q, csum_q, load_byte;
    logic             hold_full_q, done_q, err_q;
    logic             hdr_last, byte_last, more_bytes, load_now, underrun, xfer;

    assign hdr_last   = (state_q == HDR) && (bit_cnt_q == BIT_W'(LEN_W - 1));
    assign byte_last  = (bit_cnt_q == BIT_W'(7));
    assign more_bytes = (load_cnt_q != len_q);
    assign load_now   = (hdr_last && more_bytes) ||
                        ((state_q == DATA) && byte_last && more_bytes);
    assign underrun   = load_now && !hold_full_q;
    assign load_byte  = hold_full_q ? hold_q : 8'h00;

    // An underrun consumes a byte slot in the same cycle, so it must not be double-booked by a transfer.
    assign msg_tx_data_rdy_o = !hold_full_q && ((state_q == HDR) || (state_q == DATA)) &&
                               (({1'b0, slot_cnt_q} + {{LEN_W{1'b0}}, underrun}) < {1'b0, len_q});
    assign xfer = msg_tx_data_vld_i && msg_tx_data_rdy_o;

    assign msg_tx_busy_o = (state_q != IDLE);
    assign MSG_TX_FSX    = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
    assign MSG_TX        = shift_q[LEN_W-1];
    assign msg_tx_done_o = done_q;
    assign msg_tx_err_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (msg_tx_len_en_i) state_d = HDR;
            HDR:  if (hdr_last) state_d = more_bytes ? DATA : CHK;
            DATA: if (byte_last && !more_bytes) state_d = CHK;
            CHK:  if (byte_last) state_d = GAP;
            GAP:  if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q      <= '0;
            load_cnt_q <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            csum_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= underrun || (msg_tx_len_en_i && (state_q != IDLE));
            unique case (state_q)
                IDLE: begin
                    if (msg_tx_len_en_i) begin
                        len_q      <= msg_tx_len_i;
                        shift_q    <= msg_tx_len_i;
                        bit_cnt_q  <= '0;
                        csum_q     <= '0;
                        load_cnt_q <= '0;
                    end
                end
                HDR, DATA: begin
                    if (load_now) begin
                        shift_q    <= {load_byte, {(LEN_W-8){1'b0}}};
                        csum_q     <= csum_q ^ load_byte;
                        load_cnt_q <= load_cnt_q + 1'b1;
                        bit_cnt_q  <= '0;
                    end else if (state_d == CHK) begin
                        shift_q   <= {csum_q, {(LEN_W-8){1'b0}}};
                        bit_cnt_q <= '0;
                    end else begin
                        shift_q   <= shift_q << 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                CHK: begin
                    done_q <= (bit_cnt_q == BIT_W'(6));
                    if (byte_last) begin
                        shift_q   <= '0;
                        gap_cnt_q <= '0;
                    end else begin
                        shift_q   <= shift_q << 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                GAP: gap_cnt_q <= gap_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Holding register and slot count; a refill on a load cycle takes priority over the emptying.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            slot_cnt_q  <= '0;
        end else begin
            if (xfer) hold_q <= msg_tx_data_i;
            if (xfer)                             hold_full_q <= 1'b1;
            else if (load_now || state_d == GAP)  hold_full_q <= 1'b0;
            if (state_q == IDLE) slot_cnt_q <= '0;
            else                 slot_cnt_q <= slot_cnt_q + LEN_W'(xfer) + LEN_W'(underrun);
        end
    end

endmodule

// File: tb/tb_message_comm_tx.sv
// Testbench for message_comm_tx: frames are captured bit by bit from the serial pins
// and compared against header/payload/XOR-checksum values built from the frame rules.
module tb_message_comm_tx;

    localparam int LEN_W      = 16;
    localparam int GAP_CYCLES = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             msg_tx_len_en_i = 1'b0;
    logic [LEN_W-1:0] msg_tx_len_i = '0;
    logic             msg_tx_data_vld_i = 1'b0;
    logic [7:0]       msg_tx_data_i = '0;
    logic             msg_tx_data_rdy_o, msg_tx_busy_o, msg_tx_done_o, msg_tx_err_o;
    logic             MSG_TX_FSX, MSG_TX;

    message_comm_tx #(.GAP_CYCLES(GAP_CYCLES), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .msg_tx_len_en_i(msg_tx_len_en_i), .msg_tx_len_i(msg_tx_len_i),
        .msg_tx_data_vld_i(msg_tx_data_vld_i), .msg_tx_data_i(msg_tx_data_i),
        .msg_tx_data_rdy_o(msg_tx_data_rdy_o), .msg_tx_busy_o(msg_tx_busy_o),
        .msg_tx_done_o(msg_tx_done_o), .msg_tx_err_o(msg_tx_err_o),
        .MSG_TX_FSX(MSG_TX_FSX), .MSG_TX(MSG_TX)
    );

    always #5 clk_i = ~clk_i;

    int         checks = 0, errors = 0;
    logic [7:0] feed_q[$];
    logic [7:0] stim_q[$];
    logic       cap_bits[$];
    int         cycle = 0, fsx_len, done_pos, done_cnt, err_cnt, rise_cycle, fall_cycle;
    bit         rdy_seen, prev_fsx = 1'b0, frame_end, tx_idle_bad;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearCapture();
        cap_bits.delete();
        fsx_len = 0; done_pos = 0; done_cnt = 0; err_cnt = 0;
        rise_cycle = 0; fall_cycle = 0;
        rdy_seen = 1'b0; frame_end = 1'b0; tx_idle_bad = 1'b0;
    endtask

    // One clock: note whether a byte is taken at the edge, then sample and redrive 1 time unit later.
    task automatic step();
        bit xfer;
        xfer = msg_tx_data_vld_i && msg_tx_data_rdy_o && !rst_i;
        @(posedge clk_i);
        #1;
        cycle++;
        if (xfer && feed_q.size() > 0) void'(feed_q.pop_front());
        if (MSG_TX_FSX) begin
            if (!prev_fsx) rise_cycle = cycle;
            cap_bits.push_back(MSG_TX);
            fsx_len++;
            if (msg_tx_done_o) done_pos = fsx_len;
        end else if (prev_fsx) begin
            fall_cycle = cycle;
            frame_end  = 1'b1;
        end
        if (!MSG_TX_FSX && MSG_TX === 1'b1) tx_idle_bad = 1'b1;
        if (msg_tx_done_o === 1'b1) done_cnt++;
        if (msg_tx_err_o === 1'b1) err_cnt++;
        if (msg_tx_data_rdy_o === 1'b1) rdy_seen = 1'b1;
        prev_fsx = MSG_TX_FSX;
        if (feed_q.size() > 0) begin
            msg_tx_data_vld_i = 1'b1;
            msg_tx_data_i     = feed_q[0];
        end else begin
            msg_tx_data_vld_i = 1'b0;
            msg_tx_data_i     = 8'h00;
        end
    endtask

    function automatic logic [31:0] field(input int start, input int width);
        logic [31:0] v = '0;
        for (int i = 0; i < width; i++)
            v = {v[30:0], (start + i < cap_bits.size()) ? cap_bits[start + i] : 1'bx};
        return v;
    endfunction

    // Strobe a frame of n bytes (offered from bytes, vld held high while any remain) and wait it out.
    task automatic applyStimulus(input int n, input logic [7:0] bytes[$], input string tag);
        clearCapture();
        feed_q = bytes;
        msg_tx_len_en_i = 1'b1;
        msg_tx_len_i    = LEN_W'(n);
        step();
        msg_tx_len_en_i = 1'b0;
        for (int i = 0; i < LEN_W + 8*n + 60 && !frame_end; i++) step();
        checkOutput({tag, ".frame_end"}, frame_end, 1'b1);
        for (int i = 0; i < GAP_CYCLES + 4 && msg_tx_busy_o; i++) step();
    endtask

    task automatic compareFrame(input int n, input logic [7:0] bytes[$], input int exp_err, input string tag);
        logic [7:0] csum = 8'h00;
        int         exp_len = LEN_W + 8*n + 8;
        checkOutput({tag, ".len"}, fsx_len, exp_len);
        checkOutput({tag, ".hdr"}, field(0, LEN_W), n);
        for (int k = 0; k < n; k++) begin
            csum ^= bytes[k];
            checkOutput($sformatf("%s.byte%0d", tag, k), field(LEN_W + 8*k, 8), bytes[k]);
        end
        checkOutput({tag, ".csum"}, field(LEN_W + 8*n, 8), csum);
        checkOutput({tag, ".done_pos"}, done_pos, exp_len);
        checkOutput({tag, ".done_cnt"}, done_cnt, 1);
        checkOutput({tag, ".err_cnt"}, err_cnt, exp_err);
        checkOutput({tag, ".tx_idle"}, tx_idle_bad, 1'b0);
    endtask

    initial begin
        int saved_fall;
        logic [7:0] exp_q[$];

        rst_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        step();
        checkOutput("reset.outs", {MSG_TX_FSX, MSG_TX, msg_tx_busy_o, msg_tx_data_rdy_o,
                                   msg_tx_done_o, msg_tx_err_o}, 6'b0);

        stim_q = '{8'h01, 8'h02, 8'h04};
        applyStimulus(3, stim_q, "basic");
        compareFrame(3, stim_q, 0, "basic");

        stim_q = '{8'h55};
        applyStimulus(0, stim_q, "zero");
        exp_q.delete();
        compareFrame(0, exp_q, 0, "zero");
        checkOutput("zero.rdy_seen", rdy_seen, 1'b0);
        checkOutput("zero.unconsumed", feed_q.size(), 1);
        feed_q.delete();

        stim_q = '{8'hA5};
        applyStimulus(2, stim_q, "underrun");
        exp_q = '{8'hA5, 8'h00};
        compareFrame(2, exp_q, 1, "underrun");

        // Back-to-back: a strobe during DATA is refused, a strobe on the first IDLE cycle is honoured.
        clearCapture();
        stim_q = '{8'h11, 8'h22, 8'h33};
        feed_q = stim_q;
        msg_tx_len_en_i = 1'b1; msg_tx_len_i = 16'd3;
        step();
        msg_tx_len_en_i = 1'b0;
        for (int i = 0; i < 200 && fsx_len < LEN_W + 4; i++) step();
        msg_tx_len_en_i = 1'b1; msg_tx_len_i = 16'd7;
        step();
        msg_tx_len_en_i = 1'b0;
        for (int i = 0; i < 200 && !frame_end; i++) step();
        checkOutput("b2b.frame_end", frame_end, 1'b1);
        compareFrame(3, stim_q, 1, "b2b");
        for (int i = 0; i < GAP_CYCLES + 4 && msg_tx_busy_o; i++) step();
        checkOutput("b2b.idle", msg_tx_busy_o, 1'b0);
        saved_fall = fall_cycle;
        stim_q = '{8'hC3, 8'h5A};
        applyStimulus(2, stim_q, "b2b2");
        compareFrame(2, stim_q, 0, "b2b2");
        checkOutput("b2b.gap", rise_cycle - saved_fall, GAP_CYCLES + 1);

        // Reset during the payload, then a fresh single-byte frame.
        clearCapture();
        feed_q = '{8'h12, 8'h34};
        msg_tx_len_en_i = 1'b1; msg_tx_len_i = 16'd2;
        step();
        msg_tx_len_en_i = 1'b0;
        for (int i = 0; i < 200 && fsx_len < LEN_W + 6; i++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checkOutput("rst.outs", {MSG_TX_FSX, MSG_TX, msg_tx_busy_o, msg_tx_data_rdy_o}, 4'b0);
        checkOutput("rst.no_done", done_cnt, 0);
        feed_q.delete();
        step();
        stim_q = '{8'h3C};
        applyStimulus(1, stim_q, "post_rst");
        compareFrame(1, stim_q, 0, "post_rst");

        // Random frames, with surplus bytes offered that must never be taken.
        for (int f = 0; f < 8; f++) begin
            int n, extra;
            n     = $urandom_range(0, 5);
            extra = $urandom_range(0, 2);
            stim_q.delete();
            for (int k = 0; k < n + extra; k++) stim_q.push_back(8'($urandom));
            repeat ($urandom_range(0, 3)) step();
            applyStimulus(n, stim_q, $sformatf("rand%0d", f));
            compareFrame(n, stim_q, 0, $sformatf("rand%0d", f));
            checkOutput($sformatf("rand%0d.surplus", f), feed_q.size(), extra);
            feed_q.delete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
